// File: rtl/display_controller.sv
// rtl/display_controller.sv - display address sequencer for level/result screens
// Tracks game phase and blinks the won/lost word before holding it steady.
module display_controller #(
    parameter int BLINK_CYCLES  = 25_000_000,
    parameter int RESULT_BLINKS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       selecting,
    input  logic       venceu,
    input  logic       perdeu,
    input  logic       clear,
    output logic [1:0] displayAddr,
    output logic       result_active,
    output logic       result_done
);

    localparam int PW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int BW = $clog2(RESULT_BLINKS + 1);
    localparam logic [PW-1:0] PHASE_LAST  = PW'(BLINK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LIMIT = BW'(RESULT_BLINKS);

    localparam logic [1:0] ADDR_LEVEL = 2'b00;
    localparam logic [1:0] ADDR_WON   = 2'b01;
    localparam logic [1:0] ADDR_LOST  = 2'b10;
    localparam logic [1:0] ADDR_BLANK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        NIVEL,
        RES_ON,
        RES_OFF,
        HOLD
    } state_t;

    state_t        state;
    logic          res_tipo;
    logic [PW-1:0] phase;
    logic [BW-1:0] blinks;
    logic [BW-1:0] blinks_inc;
    logic          phase_end;

    assign blinks_inc = blinks + BW'(1);
    assign phase_end  = (phase == PHASE_LAST);

    function automatic logic [1:0] result_addr(input logic tipo);
        return tipo ? ADDR_LOST : ADDR_WON;
    endfunction

    // Outputs are registered together with the state so they follow it on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            res_tipo      <= 1'b0;
            phase         <= '0;
            blinks        <= '0;
            displayAddr   <= ADDR_BLANK;
            result_active <= 1'b0;
            result_done   <= 1'b0;
        end else begin
            result_done <= 1'b0;
            if (clear) begin
                state         <= IDLE;
                phase         <= '0;
                blinks        <= '0;
                displayAddr   <= ADDR_BLANK;
                result_active <= 1'b0;
            end else begin
                case (state)
                    IDLE, NIVEL: begin
                        if (perdeu || venceu) begin
                            // perdeu wins when both events arrive together
                            state         <= RES_ON;
                            res_tipo      <= perdeu;
                            phase         <= '0;
                            blinks        <= '0;
                            displayAddr   <= result_addr(perdeu);
                            result_active <= 1'b1;
                        end else if (state == IDLE && selecting) begin
                            state       <= NIVEL;
                            phase       <= '0;
                            displayAddr <= ADDR_LEVEL;
                        end else if (state == NIVEL && !selecting) begin
                            state       <= IDLE;
                            phase       <= '0;
                            displayAddr <= ADDR_BLANK;
                        end
                    end
                    RES_ON: begin
                        if (phase_end) begin
                            state       <= RES_OFF;
                            phase       <= '0;
                            displayAddr <= ADDR_BLANK;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    RES_OFF: begin
                        if (phase_end) begin
                            phase       <= '0;
                            blinks      <= blinks_inc;
                            displayAddr <= result_addr(res_tipo);
                            if (blinks_inc < BLINK_LIMIT) begin
                                state <= RES_ON;
                            end else begin
                                state       <= HOLD;
                                result_done <= 1'b1;
                            end
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    HOLD: begin
                        if (selecting) begin
                            state         <= NIVEL;
                            phase         <= '0;
                            displayAddr   <= ADDR_LEVEL;
                            result_active <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        phase         <= '0;
                        blinks        <= '0;
                        displayAddr   <= ADDR_BLANK;
                        result_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_controller.sv
// tb/tb_display_controller.sv - directed self-checking bench for display_controller
module tb_display_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       selecting;
    logic       venceu;
    logic       perdeu;
    logic       clear;
    logic [1:0] displayAddr;
    logic       result_active;
    logic       result_done;

    int errors = 0;
    int checks = 0;

    display_controller #(
        .BLINK_CYCLES (4),
        .RESULT_BLINKS(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .selecting    (selecting),
        .venceu       (venceu),
        .perdeu       (perdeu),
        .clear        (clear),
        .displayAddr  (displayAddr),
        .result_active(result_active),
        .result_done  (result_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] addr, input logic act, input logic done);
        check({tag, "_addr"}, {2'b00, displayAddr}, {2'b00, addr});
        check({tag, "_active"}, {3'b000, result_active}, {3'b000, act});
        check({tag, "_done"}, {3'b000, result_done}, {3'b000, done});
    endtask

    // Blink pattern index i counted in edges after the event edge (4 on, 4 off, twice).
    function automatic logic [1:0] blink_addr(input int i, input logic [1:0] on_addr);
        return ((i / 4) % 2 == 0) ? on_addr : 2'b11;
    endfunction

    initial begin
        reset = 1'b1; selecting = 1'b0; venceu = 1'b0; perdeu = 1'b0; clear = 1'b0;
        #1;
        check_out("reset", 2'b11, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        check_out("idle", 2'b11, 1'b0, 1'b0);

        // level selection enter/leave
        selecting = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("nivel", 2'b00, 1'b0, 1'b0);
        end
        selecting = 1'b0;
        step();
        check_out("nivel_exit", 2'b11, 1'b0, 1'b0);

        // won from NIVEL: full blink then hold
        selecting = 1'b1;
        step();
        check_out("nivel2", 2'b00, 1'b0, 1'b0);
        venceu = 1'b1;
        step();
        venceu = 1'b0;
        selecting = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("won_seq%0d", i), blink_addr(i, 2'b01), 1'b1, 1'b0);
            step();
        end
        check_out("won_hold_entry", 2'b01, 1'b1, 1'b1);
        step();
        check_out("won_hold", 2'b01, 1'b1, 1'b0);
        step();
        check_out("won_hold2", 2'b01, 1'b1, 1'b0);

        // clear from HOLD, then simultaneous events from IDLE
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_out("clear_hold", 2'b11, 1'b0, 1'b0);
        venceu = 1'b1; perdeu = 1'b1;
        step();
        venceu = 1'b0; perdeu = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("lost_seq%0d", i), blink_addr(i, 2'b10), 1'b1, 1'b0);
            venceu = (i == 5);
            step();
            venceu = 1'b0;
        end
        check_out("lost_hold_entry", 2'b10, 1'b1, 1'b1);
        step();
        check_out("lost_hold", 2'b10, 1'b1, 1'b0);

        // new game from HOLD
        selecting = 1'b1;
        step();
        check_out("hold_to_nivel", 2'b00, 1'b0, 1'b0);
        selecting = 1'b0;
        step();
        check_out("back_idle", 2'b11, 1'b0, 1'b0);

        // event ignored mid-result, then clear aborts
        venceu = 1'b1;
        step();
        venceu = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check_out($sformatf("abort_seq%0d", i), blink_addr(i, 2'b01), 1'b1, 1'b0);
            perdeu = (i == 6);
            step();
            perdeu = 1'b0;
        end
        check_out("abort_seq9", 2'b01, 1'b1, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_out("abort_clear", 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check({"abort_nodone"}, {3'b000, result_done}, 4'h0);
        end
        clear = 1'b1; venceu = 1'b1;
        step();
        clear = 1'b0; venceu = 1'b0;
        check_out("clear_vs_venceu", 2'b11, 1'b0, 1'b0);

        // asynchronous reset mid RES_ON
        venceu = 1'b1;
        step();
        venceu = 1'b0;
        step();
        check_out("pre_reset", 2'b01, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 2'b11, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        check_out("post_reset", 2'b11, 1'b0, 1'b0);
        venceu = 1'b1;
        step();
        venceu = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("restart_seq%0d", i), blink_addr(i, 2'b01), 1'b1, 1'b0);
            step();
        end
        check_out("restart_hold", 2'b01, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_controller.md
# display_controller

Sequencer that sits directly upstream of the display memory and drives its 2-bit display address. It tracks the game phase (level selection, win, loss, idle) from control-unit status lines. On a win or loss it blinks the result word a fixed number of times, then holds it steady until the next game. The level digit itself is not handled here; `modo` goes straight to the display memory.

## Interface
Parameters:
- `BLINK_CYCLES`, default 25_000_000: clock cycles per on-phase and per off-phase of a blink (≥1).
- `RESULT_BLINKS`, default 3: number of on/off pairs before steady hold (≥1).

Ports:
- `clock`, in, 1: single system clock, rising-edge.
- `reset`, in, 1: asynchronous, active-high. Returns the block to IDLE immediately.
- `selecting`, in, 1: level high while the control unit is in level selection.
- `venceu`, in, 1: one-cycle pulse, game won.
- `perdeu`, in, 1: one-cycle pulse, game lost.
- `clear`, in, 1: one-cycle pulse, drop any result and return to IDLE.
- `displayAddr`, out, 2: address to the display memory. 00 = level, 01 = won, 10 = lost, 11 = blank.
- `result_active`, out, 1: high in any result state (blink or hold).
- `result_done`, out, 1: one-cycle pulse on entering HOLD.

## Operation
- States: IDLE, NIVEL, RES_ON, RES_OFF, HOLD. A 1-bit register `res_tipo` holds the result type (0 won, 1 lost).
- `displayAddr` is decoded from the state register (Moore output):
  - IDLE → 11
  - NIVEL → 00
  - RES_ON / HOLD → 01 if `res_tipo`=0, else 10
  - RES_OFF → 11
- Phase counter: width clog2(BLINK_CYCLES), counts 0..BLINK_CYCLES-1. Cleared on every state entry.
- Blink counter: width clog2(RESULT_BLINKS+1). Incremented at each RES_OFF→RES_ON transition and on the final RES_OFF exit.
- Transitions, first match wins:
  - `clear`, from any state → IDLE. Counters are cleared.
  - `perdeu` in IDLE/NIVEL → RES_ON, `res_tipo`=1. Takes priority over a simultaneous `venceu`.
  - `venceu` in IDLE/NIVEL → RES_ON, `res_tipo`=0.
  - IDLE with `selecting`=1 → NIVEL.
  - NIVEL with `selecting`=0 → IDLE.
  - RES_ON with phase = BLINK_CYCLES-1 → RES_OFF.
  - RES_OFF with phase = BLINK_CYCLES-1:
    - → RES_ON if the blink count after increment is < RESULT_BLINKS;
    - otherwise → HOLD, with `result_done` high during the first HOLD cycle.
  - HOLD with `selecting`=1 → NIVEL (new game).
- In RES_ON, RES_OFF and HOLD, `venceu`/`perdeu` are ignored and `res_tipo` is frozen. `selecting` is ignored in RES_ON and RES_OFF.
- `result_active` = state ∈ {RES_ON, RES_OFF, HOLD}.

## Timing
- Reset values: state IDLE, `displayAddr`=11, `result_active`=0, `result_done`=0, `res_tipo`=0, counters 0. Takes effect without a clock edge.
- All inputs are sampled on the rising edge. The output changes on the same edge that updates the state, so latency is 1 edge from input to `displayAddr`. The display memory adds one more registered cycle to the HEX outputs.
- Result sequence from the edge that samples the event:
  - RES_ON and RES_OFF alternate, exactly BLINK_CYCLES cycles each, RESULT_BLINKS times.
  - HOLD is entered 2·BLINK_CYCLES·RESULT_BLINKS cycles after the event edge.
- `clear` asserted together with `venceu`/`perdeu`: `clear` wins, and the block stays in or enters IDLE.
- Reset asserted mid-blink aborts the sequence. No `result_done` pulse is issued.
- Event in the same cycle as a NIVEL→IDLE condition: the event wins, so the block goes to RES_ON.

## Test plan
All runs use BLINK_CYCLES=4, RESULT_BLINKS=2.

1. Reset, then `selecting`=1 for 3 cycles, then 0:
   - `displayAddr` is 11, then 00 starting one edge after `selecting` rises, then 11 one edge after it falls.
2. In NIVEL, pulse `venceu`. Required `displayAddr` sequence:
   - 01 ×4, 11 ×4, 01 ×4, 11 ×4, then 01 steady;
   - `result_done` high exactly one cycle, 16 cycles after the event edge;
   - `result_active`=1 throughout.
3. Pulse `venceu` and `perdeu` in the same cycle from IDLE:
   - the sequence uses 10/11, ending with 10 steady;
   - a second `venceu` pulse during the blinks changes nothing.
4. During a result, pulse `perdeu` again at cycle 6, then `clear` at cycle 9:
   - `displayAddr` goes to 11 on the next edge, `result_active`=0, no `result_done`;
   - `clear` together with `venceu` in IDLE stays in IDLE.
5. Assert `reset` asynchronously mid-RES_ON (between edges):
   - `displayAddr`=11 immediately;
   - after release, a new `venceu` restarts a full 16-cycle sequence.
6. In HOLD with 10, raise `selecting`:
   - `displayAddr`=00 on the next edge, `result_active`=0.
